// File: rtl/ej32_mem_sched_if.sv
// Core load/store and debug-dump request ports of the eJ32 RAM scheduler.
// master = requesting side, slave = scheduler.
interface ej32_mem_sched_if #(
    parameter int ASZ = 17
);
    logic           cpu_req;
    logic           cpu_we;
    logic [ASZ-1:0] cpu_a;
    logic [7:0]     cpu_d;
    logic           cpu_gnt;
    logic           cpu_vld;
    logic [7:0]     cpu_q;
    logic           dbg_req;
    logic [ASZ-1:0] dbg_a;
    logic           dbg_gnt;
    logic           dbg_vld;
    logic [7:0]     dbg_q;

    modport master (
        output cpu_req, cpu_we, cpu_a, cpu_d, dbg_req, dbg_a,
        input  cpu_gnt, cpu_vld, cpu_q, dbg_gnt, dbg_vld, dbg_q
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_a, cpu_d, dbg_req, dbg_a,
        output cpu_gnt, cpu_vld, cpu_q, dbg_gnt, dbg_vld, dbg_q
    );
endinterface

// File: rtl/ej32_mem_sched.sv
// eJ32 RAM scheduler: copies the ROM image into RAM while holding the core in
// reset, then arbitrates each RAM cycle between the core and the debug port.
module ej32_mem_sched #(
    parameter int ROM_SZ   = 8192,
    parameter int ROM_WAIT = 3,
    parameter int ASZ      = 17,
    parameter int STARVE   = 16
) (
    input  logic           clk,
    input  logic           rst,
    output logic [ASZ-1:0] rom_a,
    input  logic [7:0]     rom_d,
    output logic [ASZ-1:0] ram_a,
    output logic           ram_en,
    output logic           ram_we,
    output logic [7:0]     ram_di,
    input  logic [7:0]     ram_do,
    output logic           cpu_rst,
    output logic           boot_done,
    ej32_mem_sched_if.slave bus
);
    localparam int WW = (ROM_WAIT > 1) ? $clog2(ROM_WAIT) : 1;
    localparam int SW = $clog2(STARVE + 1);
    localparam logic [ASZ-1:0] LAST_A   = ASZ'(ROM_SZ - 1);
    localparam logic [WW-1:0]  LAST_W   = WW'(ROM_WAIT - 1);
    localparam logic [SW-1:0]  STARVE_C = SW'(STARVE);

    typedef enum logic [1:0] {
        BOOT_RD = 2'd0,
        BOOT_WR = 2'd1,
        RUN     = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [ASZ-1:0] addr_q, addr_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic           boot_done_q, boot_done_d;
    logic           cpu_rst_q, cpu_rst_d;
    logic           cpu_vld_q, cpu_vld_d;
    logic           dbg_vld_q, dbg_vld_d;
    logic [7:0]     cpu_hold_q, cpu_hold_d;
    logic [7:0]     dbg_hold_q, dbg_hold_d;
    logic           force_dbg;
    logic           cpu_gnt;
    logic           dbg_gnt;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        wait_d      = wait_q;
        starve_d    = '0;
        boot_done_d = boot_done_q;
        cpu_rst_d   = ~boot_done_q;
        force_dbg   = 1'b0;
        cpu_gnt     = 1'b0;
        dbg_gnt     = 1'b0;
        ram_a       = '0;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_di      = '0;

        unique case (state_q)
            BOOT_RD: begin
                ram_a = addr_q;
                if (wait_q == LAST_W) begin
                    wait_d  = '0;
                    state_d = BOOT_WR;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end

            BOOT_WR: begin
                ram_en = 1'b1;
                ram_we = 1'b1;
                ram_a  = addr_q;
                ram_di = rom_d;
                if (addr_q == LAST_A) begin
                    state_d     = RUN;
                    boot_done_d = 1'b1;
                end else begin
                    addr_d  = addr_q + ASZ'(1);
                    state_d = BOOT_RD;
                end
            end

            RUN: begin
                // A debug request that has lost STARVE cycles in a row pre-empts the core once.
                force_dbg = bus.dbg_req && (starve_q == STARVE_C);
                cpu_gnt   = bus.cpu_req && !force_dbg;
                dbg_gnt   = bus.dbg_req && !cpu_gnt;
                if (cpu_gnt) begin
                    ram_en = 1'b1;
                    ram_a  = bus.cpu_a;
                    ram_we = bus.cpu_we;
                    ram_di = bus.cpu_we ? bus.cpu_d : 8'h00;
                end else if (dbg_gnt) begin
                    ram_en = 1'b1;
                    ram_a  = bus.dbg_a;
                end
                if (bus.dbg_req && !dbg_gnt) begin
                    starve_d = (starve_q == STARVE_C) ? starve_q : starve_q + SW'(1);
                end
            end

            default: begin
                state_d = BOOT_RD;
                addr_d  = '0;
                wait_d  = '0;
            end
        endcase

        cpu_vld_d  = cpu_gnt && !bus.cpu_we;
        dbg_vld_d  = dbg_gnt;
        cpu_hold_d = cpu_vld_q ? ram_do : cpu_hold_q;
        dbg_hold_d = dbg_vld_q ? ram_do : dbg_hold_q;
    end

    // NOTE: sequential state uses non-blocking assignments only; comb logic above uses blocking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= BOOT_RD;
            addr_q      <= '0;
            wait_q      <= '0;
            starve_q    <= '0;
            boot_done_q <= 1'b0;
            cpu_rst_q   <= 1'b1;
            cpu_vld_q   <= 1'b0;
            dbg_vld_q   <= 1'b0;
            cpu_hold_q  <= '0;
            dbg_hold_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wait_q      <= wait_d;
            starve_q    <= starve_d;
            boot_done_q <= boot_done_d;
            cpu_rst_q   <= cpu_rst_d;
            cpu_vld_q   <= cpu_vld_d;
            dbg_vld_q   <= dbg_vld_d;
            cpu_hold_q  <= cpu_hold_d;
            dbg_hold_q  <= dbg_hold_d;
        end
    end

    // Read data comes straight from the RAM in the vld cycle and is held afterwards.
    assign rom_a       = addr_q;
    assign boot_done   = boot_done_q;
    assign cpu_rst     = cpu_rst_q;
    assign bus.cpu_gnt = cpu_gnt;
    assign bus.dbg_gnt = dbg_gnt;
    assign bus.cpu_vld = cpu_vld_q;
    assign bus.dbg_vld = dbg_vld_q;
    assign bus.cpu_q   = cpu_vld_q ? ram_do : cpu_hold_q;
    assign bus.dbg_q   = dbg_vld_q ? ram_do : dbg_hold_q;
endmodule

// File: tb/tb_ej32_mem_sched.sv
// Self-checking bench for ej32_mem_sched: delayed ROM, 1-cycle RAM, and an
// arbitration/memory reference model driven with random request traffic.
module tb_ej32_mem_sched;
    localparam int ROM_SZ   = 16;
    localparam int ROM_WAIT = 3;
    localparam int ASZ      = 17;
    localparam int STARVE   = 16;
    localparam int BOOT_CYC = ROM_SZ * (ROM_WAIT + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [ASZ-1:0] rom_a, ram_a;
    logic [7:0]     rom_d, ram_di;
    logic [7:0]     ram_do = 8'h00;
    logic           ram_en, ram_we, cpu_rst, boot_done;

    ej32_mem_sched_if #(.ASZ(ASZ)) bus ();

    ej32_mem_sched #(
        .ROM_SZ(ROM_SZ), .ROM_WAIT(ROM_WAIT), .ASZ(ASZ), .STARVE(STARVE)
    ) dut (
        .clk(clk), .rst(rst), .rom_a(rom_a), .rom_d(rom_d),
        .ram_a(ram_a), .ram_en(ram_en), .ram_we(ram_we), .ram_di(ram_di),
        .ram_do(ram_do), .cpu_rst(cpu_rst), .boot_done(boot_done), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Environment: slow ROM whose data lags its address by ROM_WAIT cycles, 1-cycle RAM.
    logic [7:0]     rom_img [ROM_SZ];
    logic [ASZ-1:0] rom_pipe [ROM_WAIT];
    logic [7:0]     ram  [1 << ASZ];
    logic [7:0]     gold [1 << ASZ];

    initial for (int i = 0; i < ROM_WAIT; i++) rom_pipe[i] = '0;

    always @(posedge clk) begin
        rom_pipe[0] <= rom_a;
        for (int i = 1; i < ROM_WAIT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_d = rom_img[int'(rom_pipe[ROM_WAIT-1]) % ROM_SZ];

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram[ram_a] <= ram_di;
            else        ram_do     <= ram[ram_a];
        end
    end

    // Reference model state.
    int       losses;
    logic     exp_cv, exp_dv;
    logic [7:0] exp_cq, exp_dq, last_cq, last_dq;

    task automatic model_reset();
        losses  = 0;
        exp_cv  = 1'b0;
        exp_dv  = 1'b0;
        exp_cq  = 8'h00;
        exp_dq  = 8'h00;
        last_cq = 8'h00;
        last_dq = 8'h00;
    endtask

    task automatic idle_inputs();
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
        bus.cpu_a   = '0;
        bus.cpu_d   = '0;
        bus.dbg_req = 1'b0;
        bus.dbg_a   = '0;
    endtask

    function automatic logic [ASZ-1:0] pick_addr();
        if ($urandom_range(0, 1) == 0) return ASZ'($urandom_range(0, 31));
        return ASZ'(32'h100 + $urandom_range(0, 7));
    endfunction

    // One RUN cycle: checks last cycle's read data, drives new requests, checks grants.
    task automatic run_cycle(input logic creq, input logic cwe, input logic [ASZ-1:0] ca,
                             input logic [7:0] cd, input logic dreq, input logic [ASZ-1:0] da);
        logic       eg_c, eg_d, starved;
        logic [7:0] want;
        @(negedge clk);
        n_tests++;
        if (bus.cpu_vld !== exp_cv) begin
            n_fail++; $display("FAIL cpu_vld t=%0t got %b want %b", $time, bus.cpu_vld, exp_cv);
        end
        want = exp_cv ? exp_cq : last_cq;
        n_tests++;
        if (bus.cpu_q !== want) begin
            n_fail++; $display("FAIL cpu_q t=%0t got %h want %h", $time, bus.cpu_q, want);
        end
        last_cq = want;
        n_tests++;
        if (bus.dbg_vld !== exp_dv) begin
            n_fail++; $display("FAIL dbg_vld t=%0t got %b want %b", $time, bus.dbg_vld, exp_dv);
        end
        want = exp_dv ? exp_dq : last_dq;
        n_tests++;
        if (bus.dbg_q !== want) begin
            n_fail++; $display("FAIL dbg_q t=%0t got %h want %h", $time, bus.dbg_q, want);
        end
        last_dq = want;

        bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_a = ca; bus.cpu_d = cd;
        bus.dbg_req = dreq; bus.dbg_a = da;
        #1;
        starved = dreq && (losses >= STARVE);
        eg_c    = creq && !starved;
        eg_d    = dreq && !eg_c;
        n_tests++;
        if ({bus.cpu_gnt, bus.dbg_gnt} !== {eg_c, eg_d}) begin
            n_fail++;
            $display("FAIL grant t=%0t got cpu=%b dbg=%b want cpu=%b dbg=%b losses=%0d",
                     $time, bus.cpu_gnt, bus.dbg_gnt, eg_c, eg_d, losses);
        end
        n_tests++;
        if ({ram_en, ram_we, cpu_rst} !== {eg_c | eg_d, eg_c & cwe, 1'b0}) begin
            n_fail++;
            $display("FAIL ram_ctl t=%0t got en=%b we=%b cpu_rst=%b want en=%b we=%b cpu_rst=0",
                     $time, ram_en, ram_we, cpu_rst, eg_c | eg_d, eg_c & cwe);
        end
        if (eg_c && cwe) begin
            n_tests++;
            if ({ram_a, ram_di} !== {ca, cd}) begin
                n_fail++; $display("FAIL wr_bus t=%0t got a=%h d=%h want a=%h d=%h",
                                   $time, ram_a, ram_di, ca, cd);
            end
        end
        losses = (dreq && !eg_d) ? ((losses < STARVE) ? losses + 1 : STARVE) : 0;
        exp_cv = eg_c && !cwe;
        exp_cq = gold[ca];
        exp_dv = eg_d;
        exp_dq = gold[da];
        if (eg_c && cwe) gold[ca] = cd;
    endtask

    // Releases reset at a negedge and times boot_done/cpu_rst against the edge count.
    task automatic wait_boot(input logic reqs);
        int rise = -1;
        int fall = -1;
        int gnts = 0;
        bus.cpu_req = reqs; bus.cpu_we = 1'b0; bus.cpu_a = ASZ'(3); bus.cpu_d = 8'h77;
        bus.dbg_req = reqs; bus.dbg_a = ASZ'(5);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= BOOT_CYC + 4; k++) begin
            @(posedge clk); #1;
            if (!boot_done && (bus.cpu_gnt || bus.dbg_gnt)) gnts++;
            if (boot_done && rise < 0) begin
                rise = k;
                idle_inputs();
            end
            if (!cpu_rst && fall < 0) fall = k;
        end
        n_tests++;
        if (rise != BOOT_CYC) begin
            n_fail++; $display("FAIL boot_done_edge got %0d want %0d", rise, BOOT_CYC);
        end
        n_tests++;
        if (fall != BOOT_CYC + 1) begin
            n_fail++; $display("FAIL cpu_rst_fall got %0d want %0d", fall, BOOT_CYC + 1);
        end
        n_tests++;
        if (gnts != 0) begin
            n_fail++; $display("FAIL boot_grants got %0d want 0", gnts);
        end
        for (int i = 0; i < ROM_SZ; i++) begin
            n_tests++;
            if (ram[i] !== rom_img[i]) begin
                n_fail++; $display("FAIL boot_copy[%0d] got %h want %h", i, ram[i], rom_img[i]);
            end
            gold[i] = rom_img[i];
        end
        model_reset();
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if ({cpu_rst, boot_done, bus.cpu_gnt, bus.dbg_gnt, bus.cpu_vld, bus.dbg_vld, ram_en, ram_we}
            !== 8'b1000_0000) begin
            n_fail++;
            $display("FAIL reset_ctl got %b want 10000000",
                     {cpu_rst, boot_done, bus.cpu_gnt, bus.dbg_gnt, bus.cpu_vld, bus.dbg_vld, ram_en, ram_we});
        end
        n_tests++;
        if ({rom_a, ram_a, ram_di, bus.cpu_q, bus.dbg_q} !== '0) begin
            n_fail++;
            $display("FAIL reset_data got rom_a=%h ram_a=%h ram_di=%h cpu_q=%h dbg_q=%h want all 0",
                     rom_a, ram_a, ram_di, bus.cpu_q, bus.dbg_q);
        end
    endtask

    task automatic test_boot();
        wait_boot(1'b0);
    endtask

    task automatic test_cpu_write_read();
        run_cycle(1'b1, 1'b1, ASZ'(32'h100), 8'h3C, 1'b0, '0);
        run_cycle(1'b1, 1'b0, ASZ'(32'h100), 8'h00, 1'b0, '0);
        run_cycle(1'b0, 1'b0, '0, 8'h00, 1'b0, '0);
        n_tests++;
        if (bus.cpu_q !== 8'h3C) begin
            n_fail++; $display("FAIL cpu_readback got %h want 3c", bus.cpu_q);
        end
    endtask

    task automatic test_priority();
        run_cycle(1'b1, 1'b0, ASZ'(3), 8'h00, 1'b1, ASZ'(9));
        n_tests++;
        if ({bus.cpu_gnt, bus.dbg_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL prio_both got %b want 10", {bus.cpu_gnt, bus.dbg_gnt});
        end
        run_cycle(1'b0, 1'b0, '0, 8'h00, 1'b1, ASZ'(9));
        n_tests++;
        if ({bus.cpu_gnt, bus.dbg_gnt} !== 2'b01) begin
            n_fail++; $display("FAIL prio_dbg got %b want 01", {bus.cpu_gnt, bus.dbg_gnt});
        end
        run_cycle(1'b0, 1'b0, '0, 8'h00, 1'b0, '0);
        n_tests++;
        if (bus.dbg_q !== (8'd9 ^ 8'hA5)) begin
            n_fail++; $display("FAIL prio_dbg_q got %h want %h", bus.dbg_q, 8'd9 ^ 8'hA5);
        end
    endtask

    task automatic test_starvation();
        logic [19:0] seen = '0;
        logic [19:0] want = 20'h1 << 16;
        run_cycle(1'b0, 1'b0, '0, 8'h00, 1'b0, '0);
        for (int i = 0; i < 20; i++) begin
            run_cycle(1'b1, 1'b0, pick_addr(), 8'h00, 1'b1, ASZ'(5));
            seen[i] = bus.dbg_gnt;
        end
        n_tests++;
        if (seen !== want) begin
            n_fail++; $display("FAIL starve_pattern got %b want %b", seen, want);
        end
        for (int i = 0; i < 2; i++) run_cycle(1'b0, 1'b0, '0, 8'h00, 1'b0, '0);
        n_tests++;
        if (bus.dbg_q !== (8'd5 ^ 8'hA5)) begin
            n_fail++; $display("FAIL starve_dbg_q got %h want %h", bus.dbg_q, 8'd5 ^ 8'hA5);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++)
            run_cycle($urandom_range(0, 3) != 0, 1'($urandom), pick_addr(), 8'($urandom),
                      1'($urandom), pick_addr());
        for (int i = 0; i < 120; i++)
            run_cycle(1'b1, 1'($urandom), pick_addr(), 8'($urandom),
                      $urandom_range(0, 7) != 0, pick_addr());
        run_cycle(1'b0, 1'b0, '0, 8'h00, 1'b0, '0);
    endtask

    task automatic test_reset_mid_boot();
        bit hit = 0;
        for (int i = 0; i < ROM_SZ; i++) begin
            rom_img[i] = 8'($urandom);
            ram[i]     = ~rom_img[i];
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(posedge clk); #1;
            if (rom_a == ASZ'(7)) hit = 1;
        end
        n_tests++;
        if (!hit) begin
            n_fail++; $display("FAIL midboot_reach_addr7 timed out, rom_a=%h", rom_a);
        end
        #1 rst = 1'b0;
        #1;
        n_tests++;
        if ({rom_a, ram_en, ram_we, cpu_rst, boot_done} !== {ASZ'(0), 4'b0010}) begin
            n_fail++;
            $display("FAIL midboot_async got rom_a=%h en=%b we=%b cpu_rst=%b done=%b want 0 0 0 1 0",
                     rom_a, ram_en, ram_we, cpu_rst, boot_done);
        end
        repeat (2) @(posedge clk);
        wait_boot(1'b1);
    endtask

    task automatic test_run_reset();
        run_cycle(1'b1, 1'b0, ASZ'(2), 8'h00, 1'b0, '0);
        @(posedge clk); #1;
        n_tests++;
        if (bus.cpu_vld !== 1'b1) begin
            n_fail++; $display("FAIL runrst_vld_before got %b want 1", bus.cpu_vld);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({bus.cpu_vld, bus.cpu_q, cpu_rst, boot_done, bus.cpu_gnt} !== {1'b0, 8'h00, 3'b100}) begin
            n_fail++;
            $display("FAIL runrst_async got vld=%b q=%h cpu_rst=%b done=%b gnt=%b want 0 00 1 0 0",
                     bus.cpu_vld, bus.cpu_q, cpu_rst, boot_done, bus.cpu_gnt);
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        model_reset();
        for (int i = 0; i < (1 << ASZ); i++) begin
            ram[i]  = 8'hEE;
            gold[i] = 8'hEE;
        end
        for (int i = 0; i < ROM_SZ; i++) rom_img[i] = 8'(i) ^ 8'hA5;

        test_reset();
        test_boot();
        test_cpu_write_read();
        test_priority();
        test_starvation();
        test_random();
        test_reset_mid_boot();
        test_run_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
